// File: rtl/cache_arb_pkg.sv
// Shared types, default widths and the grant-pick helper for the I/D cache memory-port arbiter.
package cache_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned LINE_WIDTH_DEF = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Lone requester wins outright; on contention the side that did not win last time goes next.
    function automatic grant_t pick_grant(input logic i_req, input logic d_req, input grant_t last);
        grant_t g;
        if (i_req && d_req) begin
            g = (last == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            g = GRANT_D;
        end else begin
            g = GRANT_I;
        end
        return g;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss sequencers,
// alternating on contention and steering the memory response back to the granted cache.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            state_q, state_d;
    grant_t                last_q, last_d;
    grant_t                winner;
    logic                  i_req, d_req;
    logic                  read_d, write_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LINE_WIDTH-1:0] wdata_d;

    // State, grant history and the registered memory-side stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= GRANT_I;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            pmem_read    <= read_d;
            pmem_write   <= write_d;
            pmem_address <= addr_d;
            pmem_wdata   <= wdata_d;
        end
    end

    // Next-state and next memory-side values; busy states hold everything until pmem_resp.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        read_d  = pmem_read;
        write_d = pmem_write;
        addr_d  = pmem_address;
        wdata_d = pmem_wdata;
        i_req   = i_pmem_read;
        d_req   = d_pmem_read | d_pmem_write;
        winner  = pick_grant(i_req, d_req, last_q);

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    last_d = winner;
                    if (winner == GRANT_D) begin
                        state_d = D_BUSY;
                        addr_d  = d_pmem_address;
                        // A simultaneous read+write is a protocol error; the write-back wins.
                        if (d_pmem_write) begin
                            write_d = 1'b1;
                            wdata_d = d_pmem_wdata;
                        end else begin
                            read_d  = 1'b1;
                        end
                    end else begin
                        state_d = I_BUSY;
                        addr_d  = i_pmem_address;
                        read_d  = 1'b1;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // Response steering is combinational so the granted cache sees pmem_resp in the same cycle.
    assign i_pmem_resp  = (state_q == I_BUSY) && pmem_resp;
    assign d_pmem_resp  = (state_q == D_BUSY) && pmem_resp;
    assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected memory transactions and cache responses are
// queued at stimulus time and popped by independent memory-side and cache-side monitors.
module tb_cache_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    localparam logic [LW-1:0] L_1000 = {32{8'hA5}};
    localparam logic [LW-1:0] L_1100 = {32{8'h11}};
    localparam logic [LW-1:0] L_1200 = {32{8'h12}};
    localparam logic [LW-1:0] L_1300 = {32{8'h13}};
    localparam logic [LW-1:0] L_3000 = {32{8'h30}};
    localparam logic [LW-1:0] L_4000 = {32{8'h40}};
    localparam logic [LW-1:0] L_SPUR = {32{8'hEE}};
    localparam logic [LW-1:0] WD1    = {8{32'hDEAD_BEEF}};
    localparam logic [LW-1:0] WD2    = {8{32'h0123_4567}};

    typedef struct packed {
        logic          is_write;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic          to_d;
        logic [LW-1:0] rdata;
    } resp_exp_t;

    logic          clk;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];
    int        start_cyc[$];
    int        resp_cyc[$];

    int tests;
    int fails;
    int cyc;
    int mem_lat;
    bit mem_en;
    int spur_cnt;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic fail_msg(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got event required none", nm);
    endtask

    task automatic exp_mem(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        mem_exp_t e;
        e.is_write = w;
        e.addr     = a;
        e.wdata    = wd;
        mem_q.push_back(e);
    endtask

    task automatic exp_resp(input logic to_d, input logic [LW-1:0] rd);
        resp_exp_t e;
        e.to_d  = to_d;
        e.rdata = rd;
        resp_q.push_back(e);
    endtask

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        case (a)
            32'h0000_1000: return L_1000;
            32'h0000_1100: return L_1100;
            32'h0000_1200: return L_1200;
            32'h0000_1300: return L_1300;
            32'h0000_3000: return L_3000;
            32'h0000_4000: return L_4000;
            default:       return '0;
        endcase
    endfunction

    // Memory model: fixed-latency response pulse; spur_cnt bumps inject a stray resp pulse.
    initial begin
        int cnt;
        int spur_seen;
        cnt       = 0;
        spur_seen = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            if (spur_cnt != spur_seen) begin
                spur_seen  = spur_cnt;
                pmem_resp  = 1'b1;
                pmem_rdata = L_SPUR;
                cnt        = 0;
            end else if (mem_en && (pmem_read || pmem_write)) begin
                if (cnt == mem_lat - 1) begin
                    pmem_resp = 1'b1;
                    if (pmem_read) pmem_rdata = line_of(pmem_address);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Memory-side monitor: every new strobe is one granted transaction.
    initial begin
        logic     prev;
        logic     strobe;
        mem_exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            strobe = pmem_read | pmem_write;
            if (strobe && !prev) begin
                start_cyc.push_back(cyc);
                if (mem_q.size() == 0) begin
                    fail_msg("mem_unexpected_grant");
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_write", LW'(pmem_write), LW'(e.is_write));
                    chk("mem_read", LW'(pmem_read), LW'(!e.is_write));
                    chk("mem_address", LW'(pmem_address), LW'(e.addr));
                    if (e.is_write) chk("mem_wdata", pmem_wdata, e.wdata);
                end
            end
            prev = strobe;
        end
    end

    // Cache-side monitor: responses must arrive in grant order at the right cache.
    initial begin
        resp_exp_t e;
        forever begin
            @(negedge clk);
            if (!i_pmem_resp) chk("i_rdata_zero", i_pmem_rdata, '0);
            if (!d_pmem_resp) chk("d_rdata_zero", d_pmem_rdata, '0);
            if (i_pmem_resp || d_pmem_resp) begin
                resp_cyc.push_back(cyc);
                if (i_pmem_resp && d_pmem_resp) begin
                    fail_msg("resp_both_caches");
                end else if (resp_q.size() == 0) begin
                    fail_msg("resp_unexpected");
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_port_is_d", LW'(d_pmem_resp), LW'(e.to_d));
                    chk("resp_rdata", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, e.rdata);
                end
            end
        end
    end

    task automatic wait_resp(input logic to_d, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (to_d ? d_pmem_resp : i_pmem_resp) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_msg(nm);
    endtask

    task automatic i_txn(input logic [AW-1:0] a);
        @(posedge clk);
        #1;
        i_pmem_address = a;
        i_pmem_read    = 1'b1;
        wait_resp(1'b0, "i_resp_timeout");
        @(posedge clk);
        #1;
        i_pmem_read = 1'b0;
    endtask

    task automatic d_txn(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        @(posedge clk);
        #1;
        d_pmem_address = a;
        d_pmem_wdata   = wd;
        d_pmem_read    = rd;
        d_pmem_write   = wr;
        wait_resp(1'b1, "d_resp_timeout");
        @(posedge clk);
        #1;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        i_pmem_read    = 1'b0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pmem_read", LW'(pmem_read), '0);
        chk("rst_pmem_write", LW'(pmem_write), '0);
        chk("rst_pmem_address", LW'(pmem_address), '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        chk("rst_i_resp", LW'(i_pmem_resp), '0);
        chk("rst_d_resp", LW'(d_pmem_resp), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_mem_q_empty"}, LW'(mem_q.size()), '0);
        chk({nm, "_resp_q_empty"}, LW'(resp_q.size()), '0);
    endtask

    task automatic wait_pmem_resp(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_msg(nm);
    endtask

    initial begin
        bit ok;
        tests          = 0;
        fails          = 0;
        mem_lat        = 5;
        mem_en         = 1'b1;
        spur_cnt       = 0;
        rst            = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;

        do_reset();

        // Lone I read: one-cycle grant latency, A5 line back to the I side only.
        exp_mem(1'b0, 32'h0000_1000, '0);
        exp_resp(1'b0, L_1000);
        @(posedge clk);
        #1;
        i_pmem_address = 32'h0000_1000;
        i_pmem_read    = 1'b1;
        chk("t1_read_not_yet", LW'(pmem_read), '0);
        @(posedge clk);
        #1;
        chk("t1_read_latency", LW'(pmem_read), LW'(1'b1));
        chk("t1_address", LW'(pmem_address), LW'(32'h0000_1000));
        wait_resp(1'b0, "t1_resp_timeout");
        chk("t1_d_resp_quiet", LW'(d_pmem_resp), '0);
        @(posedge clk);
        #1;
        i_pmem_read = 1'b0;
        chk("t1_strobe_dropped", LW'(pmem_read), '0);
        drain("t1");

        // Stray pmem_resp while idle must not reach either cache nor start anything.
        spur_cnt++;
        wait_pmem_resp("t6_spur_timeout");
        chk("t6_i_resp", LW'(i_pmem_resp), '0);
        chk("t6_d_resp", LW'(d_pmem_resp), '0);
        @(negedge clk);
        chk("t6_no_strobe", LW'(pmem_read | pmem_write), '0);
        drain("t6");

        // Simultaneous I and D after reset: D first, I one idle cycle after D's resp.
        do_reset();
        start_cyc.delete();
        resp_cyc.delete();
        exp_mem(1'b0, 32'h0000_4000, '0);
        exp_mem(1'b0, 32'h0000_1100, '0);
        exp_resp(1'b1, L_4000);
        exp_resp(1'b0, L_1100);
        fork
            i_txn(32'h0000_1100);
            d_txn(1'b1, 1'b0, 32'h0000_4000, '0);
        join
        drain("t2");
        if (start_cyc.size() >= 2 && resp_cyc.size() >= 1)
            chk("t2_idle_gap", LW'(start_cyc[1]), LW'(resp_cyc[0] + 2));
        else
            fail_msg("t2_missing_events");

        // Write-back then refill with an I read pending throughout: D-write, I, D-read.
        exp_mem(1'b1, 32'h0000_2000, WD1);
        exp_mem(1'b0, 32'h0000_1200, '0);
        exp_mem(1'b0, 32'h0000_3000, '0);
        exp_resp(1'b1, '0);
        exp_resp(1'b0, L_1200);
        exp_resp(1'b1, L_3000);
        fork
            i_txn(32'h0000_1200);
            begin
                d_txn(1'b0, 1'b1, 32'h0000_2000, WD1);
                d_txn(1'b1, 1'b0, 32'h0000_3000, '0);
            end
        join
        drain("t3");

        // Read and write together: the write-back wins.
        exp_mem(1'b1, 32'h0000_5000, WD2);
        exp_resp(1'b1, '0);
        d_txn(1'b1, 1'b1, 32'h0000_5000, WD2);
        drain("t4");

        // Reset during D_BUSY abandons the transaction; a later pulse reaches nobody.
        mem_en = 1'b0;
        exp_mem(1'b0, 32'h0000_4000, '0);
        @(posedge clk);
        #1;
        d_pmem_address = 32'h0000_4000;
        d_pmem_read    = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pmem_read) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_msg("t5_grant_timeout");
        @(posedge clk);
        #1;
        rst         = 1'b1;
        d_pmem_read = 1'b0;
        #1;
        chk("t5_async_read_drop", LW'(pmem_read), '0);
        chk("t5_async_write_drop", LW'(pmem_write), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        spur_cnt++;
        wait_pmem_resp("t5_pulse_timeout");
        chk("t5_i_resp", LW'(i_pmem_resp), '0);
        chk("t5_d_resp", LW'(d_pmem_resp), '0);
        mem_en = 1'b1;
        exp_mem(1'b0, 32'h0000_1300, '0);
        exp_resp(1'b0, L_1300);
        i_txn(32'h0000_1300);
        drain("t5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the instruction cache and the data cache controllers. Each cache's miss sequencer issues full-line reads and dirty-line write-backs. The arbiter grants one requester at a time, alternating on contention, and latches the winning request into registered memory-side signals. It routes the memory response back only to the granted cache. It sits between the two cache controllers and the memory / line-adapter interface.

## Interface
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 256, cache-line width in bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_pmem_read  in  1  I-cache line-read request; held until i_pmem_resp
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  out  LINE_WIDTH  read line to I-cache
- i_pmem_resp  out  1  I-cache transaction complete
- d_pmem_read  in  1  D-cache line-read request; held until d_pmem_resp
- d_pmem_write  in  1  D-cache write-back request; held until d_pmem_resp
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache write-back line
- d_pmem_rdata  out  LINE_WIDTH  read line to D-cache
- d_pmem_resp  out  1  D-cache transaction complete
- pmem_read  out  1  memory read strobe, registered
- pmem_write  out  1  memory write strobe, registered
- pmem_address  out  ADDR_WIDTH  latched address, registered
- pmem_wdata  out  LINE_WIDTH  latched write line, registered
- pmem_rdata  in  LINE_WIDTH  memory read line
- pmem_resp  in  1  memory transaction complete, single-cycle pulse

## Operation
- States: IDLE, I_BUSY, D_BUSY. There is also a 1-bit last_grant register (0 = I, 1 = D).
- IDLE:
  - i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
  - Only one request pending: grant that requester.
  - Both pending: grant the requester that was not last_grant.
  - On grant, latch the address into pmem_address and update last_grant.
  - D grant with d_pmem_write=1: latch d_pmem_wdata and assert pmem_write. Otherwise assert pmem_read.
  - If d_pmem_read and d_pmem_write are both 1 (protocol error), the write wins.
- I_BUSY / D_BUSY:
  - Hold the pmem_* registers.
  - While pmem_resp=1, pass it combinationally to the granted cache's *_pmem_resp. Pass pmem_rdata to that cache's *_rdata.
  - On the next edge, clear pmem_read/pmem_write and go to IDLE.
- The ungranted cache sees resp=0 throughout the transaction. Both *_rdata outputs are 0 while their cache's resp is 0.
- A requester that drops its request mid-transaction does not abort the transaction. The memory transaction completes and the response pulse is still issued.
- pmem_resp in IDLE is ignored.
- Write-back followed by refill: the D-cache controller issues a write, then a read. These are two independent grants. A pending I request may win the second grant.

## Timing
- Reset (asynchronous assert, released synchronously to clk) forces:
  - state=IDLE, last_grant=0 (the first contended grant goes to D).
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Both resp outputs 0 and both rdata outputs 0.
- Reset mid-transaction abandons the memory transaction; no resp is issued to either cache.
- Request seen in IDLE at cycle t → pmem_read/pmem_write high from cycle t+1.
- pmem_resp at cycle r → *_pmem_resp=1 in cycle r (zero added latency). pmem strobes are low and state is IDLE at r+1.
- A request still asserted at r+1 is treated as new; requesters must deassert the cycle after resp.
- Minimum back-to-back spacing is one IDLE cycle between transactions.
- No starvation: under continuous contention, grants strictly alternate I, D, I, D.

## Structure
- Shared package cache_arb_pkg holds:
  - arb_state_t enum {IDLE, I_BUSY, D_BUSY}.
  - grant_t enum {GRANT_I=0, GRANT_D=1}.
  - Default widths.
- No sub-module. The block is a single FSM with a small combinational pick function and a registered memory-side output stage.

## Test plan
- Lone I read, address 0x0000_1000, memory responds after 5 cycles → pmem_read high 1 cycle after request. pmem_address=0x1000. i_pmem_resp pulses with data 0xA5…A5. d_pmem_resp stays 0.
- I and D requests rise the same cycle after reset → D granted first. Once D completes, I is granted after one IDLE cycle.
- D write-back (address 0x2000, wdata pattern) then D read (0x3000), with an I read continuously pending → grant order D-write, I, D-read. pmem_wdata matches for the write only.
- d_pmem_read=d_pmem_write=1 → pmem_write=1, pmem_read=0.
- Assert rst during D_BUSY, then pulse pmem_resp → pmem strobes drop immediately and no resp reaches either cache. The next request is granted normally.
- Spurious pmem_resp in IDLE → no *_resp output and no state change.
